// File: rtl/voice_nco.sv
// Time-multiplexed multi-voice phase accumulator: one voice slot per clock after each sample tick.
// Optional hard sync on gate rising edge via `VOICE_NCO_HARD_SYNC_EN.
module voice_nco #(
  parameter int unsigned VOICES = 8,
  parameter int unsigned VIDX_W = 3,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              wr_en,
  input  logic [VIDX_W-1:0] wr_voice,
  input  logic [ACC_W-1:0]  wr_inc,
  input  logic              wr_gate,
  output logic              ce,
  output logic [6:0]        nco_phase,
  output logic [VIDX_W-1:0] voice_idx,
  output logic              voice_gate,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [VIDX_W-1:0] LastSlot = VIDX_W'(VOICES - 1);

  state_e            state_q, state_d;
  logic [VIDX_W-1:0] slot_q, slot_d;
  logic [ACC_W-1:0]  acc_q [VOICES];
  logic [ACC_W-1:0]  acc_d [VOICES];
  logic [ACC_W-1:0]  inc_q [VOICES];
  logic [ACC_W-1:0]  inc_d [VOICES];
  logic [VOICES-1:0] gate_q, gate_d;
  logic [6:0]        phase_q, phase_d;
  logic              vgate_q, vgate_d;
  logic              ovr_q, ovr_d;
  logic              issue;

  // issue marks the edge that launches slot slot_d; its accumulate happens on that same edge.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_tick) begin
          state_d = StRun;
          slot_d  = '0;
          issue   = 1'b1;
        end
      end
      StRun: begin
        if (slot_q == LastSlot) begin
          state_d = StIdle;
        end else begin
          slot_d = slot_q + 1'b1;
          issue  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q | (sample_tick & (state_q == StRun));
  end

  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    gate_d  = gate_q;
    phase_d = phase_q;
    vgate_d = vgate_q;
    if (issue) begin
      phase_d = acc_q[slot_d][ACC_W-1 -: 7];
      vgate_d = gate_q[slot_d];
      if (gate_q[slot_d]) begin
        acc_d[slot_d] = acc_q[slot_d] + inc_q[slot_d];
      end
    end
    if (wr_en) begin
      inc_d[wr_voice]  = wr_inc;
      gate_d[wr_voice] = wr_gate;
`ifdef VOICE_NCO_HARD_SYNC_EN
      // Clear overrides a coincident accumulate so the note starts at phase 0.
      if (wr_gate && !gate_q[wr_voice]) begin
        acc_d[wr_voice] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= '0;
      acc_q   <= '{default: '0};
      inc_q   <= '{default: '0};
      gate_q  <= '0;
      phase_q <= '0;
      vgate_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      gate_q  <= gate_d;
      phase_q <= phase_d;
      vgate_q <= vgate_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    ce         = (state_q == StRun);
    busy       = (state_q == StRun);
    frame_done = (state_q == StRun) && (slot_q == LastSlot);
    voice_idx  = slot_q;
    nco_phase  = phase_q;
    voice_gate = vgate_q;
    overrun    = ovr_q;
  end

endmodule

// File: tb/tb_voice_nco.sv
// Self-checking bench for voice_nco: frame-timing reference model plus directed literal checks.
module tb_voice_nco;

  localparam int unsigned VOICES = 8;
  localparam int unsigned VIDX_W = 3;
  localparam int unsigned ACC_W  = 24;
  localparam int          NV     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 1'b0;
  logic              wr_en = 1'b0;
  logic [VIDX_W-1:0] wr_voice = '0;
  logic [ACC_W-1:0]  wr_inc = '0;
  logic              wr_gate = 1'b0;
  logic              ce, voice_gate, frame_done, busy, overrun;
  logic [6:0]        nco_phase;
  logic [VIDX_W-1:0] voice_idx;

  voice_nco #(.VOICES(VOICES), .VIDX_W(VIDX_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .wr_en      (wr_en),
    .wr_voice   (wr_voice),
    .wr_inc     (wr_inc),
    .wr_gate    (wr_gate),
    .ce         (ce),
    .nco_phase  (nco_phase),
    .voice_idx  (voice_idx),
    .voice_gate (voice_gate),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame started by an accepted tick at cycle T shows slot v at T+1+v.
  logic [ACC_W-1:0] m_acc [NV];
  logic [ACC_W-1:0] m_inc [NV];
  logic             m_gate [NV];
  int               m_t = 0;
  bit               m_active = 1'b0;
  int               cyc = 0;
  logic             e_ce, e_done, e_busy, e_ovr, e_gate;
  logic [6:0]       e_phase;
  logic [VIDX_W-1:0] e_idx;

  always @(posedge clk) begin
    int  v;
    bit  was_gated;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        m_acc[i] = '0;
        m_inc[i] = '0;
        m_gate[i] = 1'b0;
      end
      m_active = 1'b0;
      e_ce = 0; e_done = 0; e_busy = 0; e_ovr = 0; e_gate = 0; e_phase = '0; e_idx = '0;
    end else begin
      if (sample_tick) begin
        if (m_active && cyc > m_t && cyc <= m_t + NV) e_ovr = 1'b1;
        else begin
          m_t      = cyc;
          m_active = 1'b1;
        end
      end
      v = cyc - m_t;
      if (m_active && v >= 0 && v < NV) begin
        e_ce    = 1'b1;
        e_idx   = VIDX_W'(v);
        e_gate  = m_gate[v];
        e_phase = m_acc[v][ACC_W-1 -: 7];
        e_done  = (v == NV - 1);
        if (m_gate[v]) m_acc[v] = m_acc[v] + m_inc[v];
      end else begin
        e_ce   = 1'b0;
        e_done = 1'b0;
      end
      e_busy = e_ce;
      if (wr_en) begin
        was_gated         = m_gate[wr_voice];
        m_inc[wr_voice]   = wr_inc;
        m_gate[wr_voice]  = wr_gate;
`ifdef VOICE_NCO_HARD_SYNC_EN
        if (wr_gate && !was_gated) m_acc[wr_voice] = '0;
`endif
      end
    end
    cyc++;
  end

  bit         chk_en = 1'b0;
  int         ce_cnt = 0;
  int         watch_v = 0;
  logic [7:0] log_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("ce", 32'(ce), 32'(e_ce));
      check("busy", 32'(busy), 32'(e_busy));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("overrun", 32'(overrun), 32'(e_ovr));
      check("voice_idx", 32'(voice_idx), 32'(e_idx));
      check("voice_gate", 32'(voice_gate), 32'(e_gate));
      check("nco_phase", 32'(nco_phase), 32'(e_phase));
      if (ce === 1'b1) begin
        ce_cnt++;
        if (int'(voice_idx) == watch_v) log_q.push_back({voice_gate, nco_phase});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write(input int v, input logic [ACC_W-1:0] inc, input logic g);
    wr_en = 1'b1; wr_voice = VIDX_W'(v); wr_inc = inc; wr_gate = g;
    step();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (VOICES + 1) step();
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    check({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_q.size()) check(name, 32'(log_q[i]), 32'(ex[i]));
    end
  endtask

  initial begin
    bit found;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    repeat (20) step();
    check("idle_ce", 32'(ce), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(frame_done), 32'd0);
    check("idle_ovr", 32'(overrun), 32'd0);
    check("idle_phase", 32'(nco_phase), 32'd0);

    // Voice 0 steps one table entry per frame; ticks every 16 cycles.
    write(0, 24'h020000, 1'b1);
    watch_v = 0;
    log_q.delete();
    for (int f = 0; f < 4; f++) begin
      ce_cnt = 0;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      repeat (15) step();
      check("slots_per_frame", 32'(ce_cnt), 32'd8);
    end
    check_log("v0_phase", 4, 8'h80, 8'h81, 8'h82, 8'h83);

    // Accumulator wrap.
    do_reset();
    write(2, 24'hFE0000, 1'b1);
    watch_v = 2;
    log_q.delete();
    repeat (3) frame();
    check_log("wrap_phase", 3, 8'h80, 8'hFF, 8'hFE, 8'h00);

    // Ungated voice holds and reports gate 0.
    write(3, 24'h020000, 1'b0);
    watch_v = 3;
    log_q.delete();
    repeat (2) frame();
    check_log("gate_off", 2, 8'h00, 8'h00, 8'h00, 8'h00);

    // Tick while busy: overrun sets, frame length unchanged.
    do_reset();
    ce_cnt = 0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (12) step();
    check("ovr_slots", 32'(ce_cnt), 32'd8);
    check("ovr_set", 32'(overrun), 32'd1);

    // Reset at slot 4 aborts the frame.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ce === 1'b1 && voice_idx == 3'd4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("slot4_seen", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ce", 32'(ce), 32'd0);
    check("abort_ovr", 32'(overrun), 32'd0);
    repeat (3) step();
    check("abort_quiet", 32'(ce), 32'd0);

    // Re-gate voice 1 after it reached phase 5.
    do_reset();
    write(1, 24'h020000, 1'b1);
    repeat (5) frame();
    write(1, 24'h020000, 1'b0);
    write(1, 24'h020000, 1'b1);
    watch_v = 1;
    log_q.delete();
    frame();
`ifdef VOICE_NCO_HARD_SYNC_EN
    check_log("resync", 1, 8'h80, 8'h00, 8'h00, 8'h00);
`else
    check_log("resync", 1, 8'h85, 8'h00, 8'h00, 8'h00);
`endif

    // Random ticks, writes and occasional resets against the model.
    for (int i = 0; i < 600; i++) begin
      sample_tick = ($urandom_range(0, 5) == 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_voice    = VIDX_W'($urandom_range(0, VOICES - 1));
      wr_inc      = ACC_W'($urandom);
      wr_gate     = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 149) == 0);
      step();
    end
    sample_tick = 1'b0;
    wr_en = 1'b0;
    rst = 1'b0;
    repeat (VOICES + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_nco.md
# voice_nco

Multi-voice, time-multiplexed phase accumulator that feeds the `phase2sample` wavetable stage.
- On every audio sample tick it walks all voices in order, one voice per clock.
- For each voice it presents the 7-bit table phase, a one-cycle `ce`, the voice index and the gate state, then advances that voice's accumulator by its programmed increment.
- Downstream stages consume one voice slot per `ce`.

## Interface
Parameters:
- VOICES, 8, number of voices (power of two, 2..32)
- VIDX_W, 3, voice index width, log2(VOICES)
- ACC_W, 24, accumulator and increment width (≥ 8)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- sample_tick  in  1  one-cycle pulse per audio sample; starts a frame
- wr_en  in  1  write strobe for the per-voice register
- wr_voice  in  VIDX_W  voice selected by the write
- wr_inc  in  ACC_W  phase increment to store
- wr_gate  in  1  gate (note on) to store
- ce  out  1  slot valid, one cycle per voice per frame
- nco_phase  out  7  accumulator bits [ACC_W-1:ACC_W-7] of the current voice
- voice_idx  out  VIDX_W  voice of the current slot
- voice_gate  out  1  gate of the current voice
- frame_done  out  1  pulse on the last slot of a frame
- busy  out  1  frame in progress
- overrun  out  1  sticky; set when a tick arrives while busy

## Operation
- Storage: acc[v], inc[v] and gate[v] for every voice, held in flops.
- State machine: IDLE and RUN.
  - IDLE → RUN on `sample_tick`; the slot counter loads 0.
  - In RUN, the counter increments each cycle.
  - At counter = VOICES-1: back to IDLE and `frame_done` = 1.
- Per slot v, outputs are registered from pre-update values:
  - ce = 1, voice_idx = v, voice_gate = gate[v], nco_phase = acc[v][ACC_W-1:ACC_W-7].
  - In the same cycle, if gate[v] = 1: acc[v] ← acc[v] + inc[v], modulo 2^ACC_W; wrap-around is silent.
  - If gate[v] = 0, acc[v] holds.
- Every voice gets a slot whatever its gate. Downstream uses voice_gate to mute.
- Writes are accepted in any state, taking effect the cycle after `wr_en`.
  - A write to the voice being updated in the same cycle: the update uses the old inc; the new inc applies from the next frame.
- `sample_tick` while busy, including the `frame_done` cycle: the tick is ignored and overrun is set. Only `rst` clears overrun.
- When not in RUN: ce = 0, frame_done = 0, and nco_phase/voice_idx/voice_gate are held at the last slot's values.

## Timing
- Tick at cycle T: ce slot v appears at T+1+v. The last slot and frame_done are at T+VOICES.
- busy is high from T+1 through T+VOICES.
- The earliest accepted next tick is at T+VOICES+1, giving a minimum tick period of VOICES+1 cycles.
- Reset values: all outputs 0, all acc/inc/gate 0, state IDLE, overrun 0.
- Reset mid-frame aborts the frame: ce drops to 0 the cycle after rst is sampled, and no further slots are issued.
- rst has priority over `sample_tick` and `wr_en` in the same cycle.

## Configuration
- `VOICE_NCO_HARD_SYNC_EN` defined: a write that changes gate[v] from 0 to 1 also clears acc[v] to 0.
  - The note therefore starts at phase 0 on its next slot.
  - If the write coincides with voice v's slot, the clear wins over the accumulate.
- Not defined: gate writes never touch acc. A re-gated voice resumes from its held phase.

## Test plan
- After reset, with no tick for 20 cycles: ce, busy, frame_done and overrun stay 0, and nco_phase = 0.
- Write voice 0 with inc = 0x020000, gate = 1, then 4 ticks spaced 16 cycles apart:
  - voice 0 nco_phase reads 0, 1, 2, 3.
  - Every frame shows 8 ce slots with voice_idx 0..7, and frame_done coincides with voice_idx 7.
- Wrap test: inc = 0xFE0000, gate = 1 over 3 frames → nco_phase reads 0x00, 0x7F, 0x7E.
- Gate test: voice 3 with inc = 0x020000 and gate = 0 → nco_phase stays 0 and voice_gate = 0 for voice 3.
- Overrun and reset:
  - A second tick 3 cycles after the first → overrun = 1 and the frame is still exactly 8 slots.
  - rst asserted at slot 4 → ce = 0 the next cycle and overrun clears.
- Hard sync:
  - Run voice 1 to phase 5, gate off, gate on, then tick.
  - With `VOICE_NCO_HARD_SYNC_EN` the phase reads 0; without it the phase reads 5.
